// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder with a fixed
// number of wait states between request acceptance and response.
// Stores commit byte lanes at the acceptance edge. Loads are read at the edge
// that enters the response state. Misaligned or out-of-range requests complete
// with rsp_err set and rsp_rdata forced to zero.
module dmem_responder #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW         = $clog2(DEPTH);
  localparam int          LANE_W     = 8;
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH) * 33'd4;
  localparam logic [3:0]  CNT_LOAD   = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_next_s;
  logic [3:0]    cnt_r;
  logic [3:0]    cnt_next_s;

  logic          req_ready_r;
  logic          rsp_valid_r;
  logic          rsp_err_r;
  logic [31:0]   rsp_rdata_r;
  logic          req_ready_next_s;
  logic          rsp_valid_next_s;

  logic          accept_s;
  logic          rsp_fire_s;
  logic          enter_resp_s;

  logic [AW-1:0] req_idx_s;
  logic          req_err_s;
  logic [AW-1:0] idx_r;
  logic          err_r;
  logic          we_r;
  logic [AW-1:0] rd_idx_s;
  logic          rd_err_s;
  logic          rd_we_s;

  logic [31:0]   mem_r [DEPTH];

  // Merge the enabled byte lanes of new_word over old_word.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] result;
    result = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        result[LANE_W*i +: LANE_W] = new_word[LANE_W*i +: LANE_W];
      end else begin
        result[LANE_W*i +: LANE_W] = old_word[LANE_W*i +: LANE_W];
      end
    end
    return result;
  endfunction

  assign accept_s     = req_valid && req_ready_r;
  assign rsp_fire_s   = rsp_valid_r && rsp_ready;
  assign req_idx_s    = req_addr[AW+1:2];
  assign req_err_s    = (req_addr[1:0] != 2'b00) || ({1'b0, req_addr} >= ADDR_LIMIT);
  assign enter_resp_s = (state_next_s == ST_RESP) && (state_r != ST_RESP);

  // Source of the response: live request when responding straight from IDLE,
  // otherwise the fields captured at acceptance.
  always_comb begin
    rd_idx_s = idx_r;
    rd_err_s = err_r;
    rd_we_s  = we_r;
    if (state_r == ST_IDLE) begin
      rd_idx_s = req_idx_s;
      rd_err_s = req_err_s;
      rd_we_s  = req_we;
    end else begin
      rd_idx_s = idx_r;
      rd_err_s = err_r;
      rd_we_s  = we_r;
    end
  end

  // Next-state and wait counter logic.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (WAIT_STATES == 0) begin
            state_next_s = ST_RESP;
            cnt_next_s   = 4'd0;
          end else begin
            state_next_s = ST_WAIT;
            cnt_next_s   = CNT_LOAD;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 4'd0) begin
          state_next_s = ST_RESP;
        end else begin
          cnt_next_s = cnt_r - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_fire_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_RESP;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        cnt_next_s   = 4'd0;
      end
    endcase
  end

  // Handshake outputs derived from the upcoming state so they can be registered.
  always_comb begin
    req_ready_next_s = (state_next_s == ST_IDLE);
    rsp_valid_next_s = (state_next_s == ST_RESP);
  end

  // State and wait counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Registered handshake outputs; req_ready stays low while reset is held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_ready_r <= 1'b0;
      rsp_valid_r <= 1'b0;
    end else begin
      req_ready_r <= req_ready_next_s;
      rsp_valid_r <= rsp_valid_next_s;
    end
  end

  // Capture request fields at acceptance and build the response on entry to RESP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_r       <= '0;
      err_r       <= 1'b0;
      we_r        <= 1'b0;
      rsp_rdata_r <= 32'd0;
      rsp_err_r   <= 1'b0;
    end else begin
      if (accept_s) begin
        idx_r <= req_idx_s;
        err_r <= req_err_s;
        we_r  <= req_we;
      end
      if (enter_resp_s) begin
        rsp_err_r <= rd_err_s;
        if (!rd_we_s && !rd_err_s) begin
          rsp_rdata_r <= mem_r[rd_idx_s];
        end else begin
          rsp_rdata_r <= 32'd0;
        end
      end else if (rsp_fire_s) begin
        rsp_rdata_r <= 32'd0;
        rsp_err_r   <= 1'b0;
      end
    end
  end

  // Byte-lane store at the acceptance edge; contents are not touched by reset.
  always_ff @(posedge clk) begin
    if (accept_s && req_we && !req_err_s) begin
      mem_r[req_idx_s] <= merge_bytes(mem_r[req_idx_s], req_wdata, req_be);
    end
  end

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: two instances (2 wait states and 0 wait
// states) share stimulus; a selector routes req_valid and picks the outputs.
module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int WS_A  = 2;
  localparam int WS_B  = 0;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_ready;
  int          sel;

  logic        req_valid_a, req_ready_a, rsp_valid_a, rsp_err_a;
  logic [31:0] rsp_rdata_a;
  logic        req_valid_b, req_ready_b, rsp_valid_b, rsp_err_b;
  logic [31:0] rsp_rdata_b;

  logic        ready_m, rsp_valid_m, rsp_err_m;
  logic [31:0] rsp_rdata_m;

  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;

  // Reference memory image per instance
  logic [31:0] mdl [2][DEPTH];

  assign req_valid_a = req_valid && (sel == 0);
  assign req_valid_b = req_valid && (sel == 1);
  assign ready_m     = (sel == 0) ? req_ready_a : req_ready_b;
  assign rsp_valid_m = (sel == 0) ? rsp_valid_a : rsp_valid_b;
  assign rsp_err_m   = (sel == 0) ? rsp_err_a   : rsp_err_b;
  assign rsp_rdata_m = (sel == 0) ? rsp_rdata_a : rsp_rdata_b;

  dmem_responder #(.DEPTH(DEPTH), .WAIT_STATES(WS_A)) u_dut_a (
    .clk(clk), .reset(reset), .req_valid(req_valid_a), .req_ready(req_ready_a),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a)
  );

  dmem_responder #(.DEPTH(DEPTH), .WAIT_STATES(WS_B)) u_dut_b (
    .clk(clk), .reset(reset), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural memory: error rule, byte-lane store, word load.
  function automatic void model_acc(input int s, input logic we, input logic [31:0] addr,
                                    input logic [31:0] wdata, input logic [3:0] be,
                                    output logic [31:0] rd, output logic er);
    int idx;
    er = (addr % 4 != 0) || (addr >= 32'(4 * DEPTH));
    rd = 32'd0;
    if (!er) begin
      idx = int'(addr / 4);
      if (we) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) mdl[s][idx][8*b +: 8] = wdata[8*b +: 8];
        end
      end else begin
        rd = mdl[s][idx];
      end
    end
  endfunction

  // One complete access on the selected instance with rsp_ready held high.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, output logic [31:0] rd, output logic er,
                        output int lat, output int acc_cyc);
    int n;
    n = 0;
    rd = 32'd0;
    er = 1'b0;
    lat = -1;
    acc_cyc = -1;
    while (!ready_m && n < 40) begin
      @(negedge clk);
      n++;
    end
    n_chk++;
    if (ready_m !== 1'b1) begin
      n_fail++;
      $display("FAIL access_ready: req_ready=%b after %0d cycles, required 1", ready_m, n);
      return;
    end
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    @(posedge clk);
    @(negedge clk);
    acc_cyc   = cyc;
    req_valid = 1'b0;
    req_we    = 1'($urandom_range(0, 1));
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_be    = 4'($urandom_range(0, 15));
    lat = 0;
    while (!rsp_valid_m && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    n_chk++;
    if (rsp_valid_m !== 1'b1) begin
      n_fail++;
      $display("FAIL access_rsp_timeout: rsp_valid=%b after %0d cycles, required 1", rsp_valid_m, lat);
      return;
    end
    rd = rsp_rdata_m;
    er = rsp_err_m;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_chk++;
    if ({req_ready_a, rsp_valid_a, rsp_err_a, rsp_rdata_a} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_a: ready/valid/err/rdata=%b/%b/%b/%h, required all 0",
               req_ready_a, rsp_valid_a, rsp_err_a, rsp_rdata_a);
    end
    n_chk++;
    if ({req_ready_b, rsp_valid_b, rsp_err_b, rsp_rdata_b} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_b: ready/valid/err/rdata=%b/%b/%b/%h, required all 0",
               req_ready_b, rsp_valid_b, rsp_err_b, rsp_rdata_b);
    end
    reset = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({req_ready_a, req_ready_b, rsp_valid_a, rsp_valid_b} !== 4'b1100) begin
      n_fail++;
      $display("FAIL reset_release: ready_a/ready_b/valid_a/valid_b=%b%b%b%b, required 1100",
               req_ready_a, req_ready_b, rsp_valid_a, rsp_valid_b);
    end
  endtask

  task automatic test_store_load();
    logic [31:0] rd;
    logic        er;
    int          lat, c;
    sel = 0;
    access(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat, c);
    n_chk++;
    if ({er, rd} !== 33'd0 || lat != WS_A) begin
      n_fail++;
      $display("FAIL store_rsp: err=%b rdata=%h lat=%0d, required 0/00000000/%0d", er, rd, lat, WS_A);
    end
    access(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, c);
    n_chk++;
    if (lat != WS_A) begin
      n_fail++;
      $display("FAIL load_latency: got %0d, required %0d", lat, WS_A);
    end
    n_chk++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
      n_fail++;
      $display("FAIL load_data: rdata=%h err=%b, required deadbeef/0", rd, er);
    end
  endtask

  task automatic test_byte_enables();
    logic [31:0] rd;
    logic        er;
    int          lat, c;
    sel = 0;
    access(1'b1, 32'h20, 32'h11223344, 4'hF, rd, er, lat, c);
    access(1'b1, 32'h20, 32'hAABBCCDD, 4'h5, rd, er, lat, c);
    access(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, rd, er, lat, c);
    n_chk++;
    if (er !== 1'b0) begin
      n_fail++;
      $display("FAIL be_zero_err: got %b, required 0", er);
    end
    access(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat, c);
    n_chk++;
    if (rd !== 32'h11BB33DD || er !== 1'b0) begin
      n_fail++;
      $display("FAIL byte_enable: rdata=%h err=%b, required 11bb33dd/0", rd, er);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd;
    logic        er;
    int          lat, c;
    sel = 0;
    access(1'b1, 32'h0, 32'h0BADF00D, 4'hF, rd, er, lat, c);
    access(1'b0, 32'h22, 32'h0, 4'h0, rd, er, lat, c);
    n_chk++;
    if (er !== 1'b1 || rd !== 32'd0) begin
      n_fail++;
      $display("FAIL misaligned_load: err=%b rdata=%h, required 1/00000000", er, rd);
    end
    access(1'b1, 32'(4 * DEPTH), 32'hFFFFFFFF, 4'hF, rd, er, lat, c);
    n_chk++;
    if (er !== 1'b1 || rd !== 32'd0 || lat != WS_A) begin
      n_fail++;
      $display("FAIL range_store: err=%b rdata=%h lat=%0d, required 1/00000000/%0d", er, rd, lat, WS_A);
    end
    access(1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat, c);
    n_chk++;
    if (rd !== 32'h0BADF00D || er !== 1'b0) begin
      n_fail++;
      $display("FAIL word0_intact: rdata=%h err=%b, required 0badf00d/0", rd, er);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd;
    logic        er;
    int          lat, c;
    sel = 1;
    access(1'b1, 32'h10, 32'hCAFEF00D, 4'hF, rd, er, lat, c);
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h10;
    @(posedge clk);
    @(negedge clk);
    // A store offered while not ready must be ignored.
    req_we    = 1'b1;
    req_wdata = 32'h12345678;
    req_be    = 4'hF;
    n_chk++;
    if (rsp_valid_m !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_first: rsp_valid=%b, required 1", rsp_valid_m);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_chk++;
      if ({rsp_valid_m, ready_m, rsp_err_m, rsp_rdata_m} !== {3'b100, 32'hCAFEF00D}) begin
        n_fail++;
        $display("FAIL bp_hold%0d: valid/ready/err/rdata=%b/%b/%b/%h, required 1/0/0/cafef00d",
                 i, rsp_valid_m, ready_m, rsp_err_m, rsp_rdata_m);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n_chk++;
    if (rsp_valid_m !== 1'b0 || ready_m !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: valid=%b ready=%b, required 0/1", rsp_valid_m, ready_m);
    end
    access(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, c);
    n_chk++;
    if (rd !== 32'hCAFEF00D) begin
      n_fail++;
      $display("FAIL bp_ignored_store: rdata=%h, required cafef00d", rd);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    logic        er;
    int          lat, c;
    logic        seen;
    sel  = 0;
    seen = 1'b0;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h30;
    req_wdata = 32'h5;
    req_be    = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    reset     = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen = seen | rsp_valid_m;
    end
    n_chk++;
    if (ready_m !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_ready: got %b, required 0", ready_m);
    end
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      seen = seen | rsp_valid_m;
    end
    n_chk++;
    if (seen !== 1'b0 || ready_m !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset_state: rsp_valid_seen=%b ready=%b, required 0/1", seen, ready_m);
    end
    access(1'b0, 32'h30, 32'h0, 4'h0, rd, er, lat, c);
    n_chk++;
    if (rd !== 32'h5 || er !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_commit: rdata=%h err=%b, required 00000005/0", rd, er);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d [8];
    logic [31:0] rd;
    logic        er;
    int          lat, c, prev;
    sel  = 1;
    prev = -1;
    for (int i = 0; i < 16; i++) begin
      if (i < 8) begin
        d[i] = $urandom;
        access(1'b1, 32'h100 + 32'(4 * i), d[i], 4'hF, rd, er, lat, c);
      end else begin
        access(1'b0, 32'h100 + 32'(4 * (i - 8)), 32'h0, 4'h0, rd, er, lat, c);
        n_chk++;
        if (rd !== d[i-8]) begin
          n_fail++;
          $display("FAIL b2b_data%0d: got %h, required %h", i - 8, rd, d[i-8]);
        end
      end
      if (i > 0) begin
        n_chk++;
        if (c - prev != WS_B + 2) begin
          n_fail++;
          $display("FAIL b2b_period%0d: got %0d cycles, required %0d", i, c - prev, WS_B + 2);
        end
      end
      prev = c;
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, exp_rd, addr, wdata;
    logic        er, exp_er, we;
    logic [3:0]  be;
    int          lat, c, r, exp_lat;
    for (int s = 0; s < 2; s++) begin
      sel     = s;
      exp_lat = (s == 0) ? WS_A : WS_B;
      for (int w = 0; w < 16; w++) begin
        wdata = $urandom;
        model_acc(s, 1'b1, 32'(4 * w), wdata, 4'hF, exp_rd, exp_er);
        access(1'b1, 32'(4 * w), wdata, 4'hF, rd, er, lat, c);
      end
      for (int k = 0; k < 30; k++) begin
        r = $urandom_range(0, 9);
        if (r == 0) addr = 32'(4 * $urandom_range(0, 15) + $urandom_range(1, 3));
        else if (r == 1) addr = 32'(4 * DEPTH) + ($urandom & 32'h7FFF_FFFC);
        else addr = 32'(4 * $urandom_range(0, 15));
        we    = 1'($urandom_range(0, 1));
        wdata = $urandom;
        be    = 4'($urandom_range(0, 15));
        model_acc(s, we, addr, wdata, be, exp_rd, exp_er);
        access(we, addr, wdata, be, rd, er, lat, c);
        n_chk++;
        if (rd !== exp_rd || er !== exp_er || lat != exp_lat) begin
          n_fail++;
          $display("FAIL random_s%0d_%0d: we=%b addr=%h rdata=%h err=%b lat=%0d, required %h/%b/%0d",
                   s, k, we, addr, rd, er, lat, exp_rd, exp_er, exp_lat);
        end
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    sel       = 0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 32'd0;
    req_wdata = 32'd0;
    req_be    = 4'd0;
    rsp_ready = 1'b1;
    #1 reset  = 1'b0;
    test_reset();
    test_store_load();
    test_byte_enables();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
